count_checker: RTL and testbench
================================

# count_checker

Passive monitor for the free-running up-counter interface (enable, count, overflow). It sits beside a counter instance in the same clock domain and observes the enable driven into the counter plus the count and overflow coming out. It rebuilds the expected count sequence and flags any deviation, with a sticky error count, error kind, lock status and a wrap tally. It drives nothing back into the counter.

## Interface
- WIDTH, 8, width of observed count
- ERR_WIDTH, 16, width of err_count (saturating)
- WRAP_WIDTH, 16, width of wrap_count (modulo)
- LOCK_CYCLES, 4, consecutive clean checks required to relock from FAULT (≥1)

- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  enable as presented to the monitored counter
- count  in  WIDTH  counter output
- overflow  in  1  counter overflow output
- clear_err  in  1  clears err_count and err_kind
- locked  out  1  high while in TRACK
- err_pulse  out  1  one-cycle strobe per mismatching sample
- err_kind  out  2  bit0 count mismatch, bit1 overflow mismatch; kind of last error, sticky
- err_count  out  ERR_WIDTH  mismatching samples since reset/clear, saturating
- wrap_count  out  WRAP_WIDTH  verified wraps (all-ones → 0), modulo 2^WRAP_WIDTH

## Operation
- Counter behaviour modelled: on each edge with enable=1, count ← count+1 (mod 2^WIDTH) and overflow ← (count == all-ones). With enable=0, both hold.
- Checker registers ref_count, ref_ovf and en_d (enable from the previous edge).
- Expected at edge k: if en_d, then count == ref_count+1 mod 2^WIDTH and overflow == (ref_count == all-ones). Otherwise count == ref_count and overflow == ref_ovf.
- ref_count, ref_ovf and en_d reload from the observed inputs on every non-reset edge, whether or not the sample matched.
- States:
  - ACQ (reset state): capture reference only, no check → TRACK.
  - TRACK: check every edge. Match: stay. Mismatch: → FAULT.
  - FAULT: check every edge. Mismatch: clear good-run counter, stay. Match: increment good-run counter; on the LOCK_CYCLES-th consecutive match → TRACK.
- Mismatch (TRACK or FAULT) at edge k:
  - err_pulse=1 for the cycle after edge k.
  - err_kind ← {ovf_mis, cnt_mis}.
  - err_count ← err_count+1, saturating at all-ones.
- A hold cycle (enable low, values unchanged) is a match and counts toward relock.
- Wrap: in TRACK, a matching sample with en_d=1 and ref_count all-ones increments wrap_count. Wrap_count wraps modulo 2^WRAP_WIDTH.
- clear_err and a mismatch on the same edge: err_count ← 1, err_kind ← new kind. clear_err alone: err_count ← 0, err_kind ← 0. clear_err does not affect state or wrap_count.
- Independent counter reset (checker not reset): seen as a count jump → mismatch → FAULT, then relock after LOCK_CYCLES clean samples.

## Timing
- Reset values: locked=0, err_pulse=0, err_kind=0, err_count=0, wrap_count=0, state=ACQ, good-run counter=0.
- rst mid-operation, including in FAULT: all of the above on the next edge. Pending err_pulse is dropped.
- All outputs are registered. Detection latency is 1 edge: a bad value present before edge k gives err_pulse high in cycle k+1.
- locked rises after the first edge with rst=0 (ACQ → TRACK).
- locked falls on the same edge err_pulse rises.
- Relock: locked rises after the LOCK_CYCLES-th clean edge following the last mismatch.
- Back-to-back mismatches: err_pulse stays high across consecutive cycles, one count per cycle.

## Test plan
- Reset, then enable=1 continuously for 520 cycles (WIDTH=8) → locked=1 after first edge, err_pulse never asserted, err_count=0, wrap_count=2.
- Pseudo-random enable for 2000 cycles against a correct counter → err_count=0, locked stays 1, wrap_count equals the number of counter 0xFF→0x00 transitions.
- Force count to 0x55 for one cycle when 0x10 is expected → err_pulse one cycle, err_kind=01, err_count=1, locked=0. The forced value becomes the new reference, so the next sample (0x11 vs expected 0x56) also mismatches: err_count=2. Then locked returns to 1 after 4 clean edges.
- Hold overflow at 1 while count advances 0x03→0x04 → err_kind=10, err_count=1, FAULT entered.
- clear_err on the same edge as a mismatch → err_count=1. With ERR_WIDTH=2 and 5 mismatches → err_count saturates at 3.
- Assert rst while in FAULT with err_count=3 → next cycle: all outputs 0, state ACQ. locked=1 one edge after rst drops.

Source files
------------

// File: rtl/count_checker.sv
// rtl/count_checker.sv - passive monitor for a free-running up-counter
// Rebuilds the expected count/overflow sequence and reports deviations.
module count_checker #(
  parameter int WIDTH       = 8,
  parameter int ERR_WIDTH   = 16,
  parameter int WRAP_WIDTH  = 16,
  parameter int LOCK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      count,
  input  logic                  overflow,
  input  logic                  clear_err,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [1:0]            err_kind,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [WRAP_WIDTH-1:0] wrap_count
);

  typedef enum logic [1:0] {ACQ, TRACK, FAULT} state_t;

  localparam int GW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [GW-1:0]        GOOD_LAST = GW'(LOCK_CYCLES - 1);
  localparam logic [WIDTH-1:0]     CNT_MAX   = '1;
  localparam logic [ERR_WIDTH-1:0] ERR_MAX   = '1;

  state_t           state;
  logic [WIDTH-1:0] ref_count;
  logic             ref_ovf;
  logic             en_d;
  logic [GW-1:0]    good_run;

  logic [WIDTH-1:0] exp_count;
  logic             exp_ovf;
  logic             ref_at_max;
  logic             cnt_mis;
  logic             ovf_mis;
  logic             mis;

  // Expected sample is derived purely from the previous sample and its enable.
  always_comb begin
    ref_at_max = (ref_count == CNT_MAX);
    exp_count  = en_d ? ref_count + WIDTH'(1) : ref_count;
    exp_ovf    = en_d ? ref_at_max : ref_ovf;
    cnt_mis    = (count != exp_count);
    ovf_mis    = (overflow != exp_ovf);
    mis        = (state != ACQ) && (cnt_mis || ovf_mis);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACQ;
      ref_count  <= '0;
      ref_ovf    <= 1'b0;
      en_d       <= 1'b0;
      good_run   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_kind   <= 2'b00;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      ref_count <= count;
      ref_ovf   <= overflow;
      en_d      <= enable;
      err_pulse <= mis;

      // A mismatch on the same edge as clear_err restarts the tally at one.
      if (mis) begin
        err_kind <= {ovf_mis, cnt_mis};
        if (clear_err)
          err_count <= ERR_WIDTH'(1);
        else if (err_count != ERR_MAX)
          err_count <= err_count + ERR_WIDTH'(1);
      end else if (clear_err) begin
        err_kind  <= 2'b00;
        err_count <= '0;
      end

      case (state)
        ACQ: begin
          state    <= TRACK;
          locked   <= 1'b1;
          good_run <= '0;
        end
        TRACK: begin
          if (mis) begin
            state    <= FAULT;
            locked   <= 1'b0;
            good_run <= '0;
          end else if (en_d && ref_at_max) begin
            wrap_count <= wrap_count + WRAP_WIDTH'(1);
          end
        end
        FAULT: begin
          if (mis) begin
            good_run <= '0;
          end else if (good_run == GOOD_LAST) begin
            state    <= TRACK;
            locked   <= 1'b1;
            good_run <= '0;
          end else begin
            good_run <= good_run + GW'(1);
          end
        end
        default: begin
          state    <= ACQ;
          locked   <= 1'b0;
          good_run <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - self-checking bench for count_checker
// A correct counter model drives the DUT; faults are injected by overriding its outputs.
module tb_count_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  count;
  logic        overflow;
  logic        clear_err;
  logic        locked, err_pulse;
  logic [1:0]  err_kind;
  logic [15:0] err_count, wrap_count;
  logic        locked2, err_pulse2;
  logic [1:0]  err_kind2;
  logic [1:0]  err_count2;
  logic [15:0] wrap_count2;

  int errors = 0;
  int checks = 0;

  // correct counter being monitored
  logic [7:0] c_cnt;
  logic       c_ovf;

  // reference model of the checker
  bit         have_prev;
  logic [7:0] last_c;
  logic       last_o, last_e;
  bit         m_locked, m_pulse;
  logic [1:0] m_kind;
  int         m_err, m_err2, m_wrap, m_clean;

  count_checker dut (
    .clk(clk), .rst(rst), .enable(enable), .count(count), .overflow(overflow),
    .clear_err(clear_err), .locked(locked), .err_pulse(err_pulse),
    .err_kind(err_kind), .err_count(err_count), .wrap_count(wrap_count)
  );

  count_checker #(.ERR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .count(count), .overflow(overflow),
    .clear_err(clear_err), .locked(locked2), .err_pulse(err_pulse2),
    .err_kind(err_kind2), .err_count(err_count2), .wrap_count(wrap_count2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    have_prev = 0; m_locked = 0; m_pulse = 0; m_kind = 2'b00;
    m_err = 0; m_err2 = 0; m_wrap = 0; m_clean = 0;
  endtask

  task automatic model_edge(input logic [7:0] c, input logic o, input logic e, input logic clr);
    logic [7:0] want_c;
    logic       want_o, cm, om;
    if (!have_prev) begin
      m_pulse = 0; m_locked = 1; m_clean = 0;
      if (clr) begin m_kind = 2'b00; m_err = 0; m_err2 = 0; end
    end else begin
      want_c = last_e ? last_c + 8'd1 : last_c;
      want_o = last_e ? (last_c == 8'hFF) : last_o;
      cm = (c != want_c);
      om = (o != want_o);
      m_pulse = cm | om;
      if (m_pulse) begin
        m_kind = {om, cm};
        m_err  = clr ? 1 : ((m_err < 65535) ? m_err + 1 : 65535);
        m_err2 = clr ? 1 : ((m_err2 < 3) ? m_err2 + 1 : 3);
        m_locked = 0; m_clean = 0;
      end else begin
        if (clr) begin m_kind = 2'b00; m_err = 0; m_err2 = 0; end
        if (m_locked) begin
          if (last_e && last_c == 8'hFF) m_wrap = (m_wrap + 1) % 65536;
        end else begin
          m_clean++;
          if (m_clean == 4) begin m_locked = 1; m_clean = 0; end
        end
      end
    end
    last_c = c; last_o = o; last_e = e; have_prev = 1;
  endtask

  // One clock: inputs as currently presented are sampled, then the counter advances.
  task automatic cyc(input logic e);
    enable = e;
    if (rst) model_reset();
    else model_edge(count, overflow, e, clear_err);
    @(posedge clk); #1;
    if (rst) begin
      c_cnt = 8'h00; c_ovf = 1'b0;
    end else if (e) begin
      c_ovf = (c_cnt == 8'hFF);
      c_cnt = c_cnt + 8'd1;
    end
    count = c_cnt; overflow = c_ovf;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0); cyc(1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_err = 1'b0; c_cnt = 8'h00; c_ovf = 1'b0; count = 8'h00; overflow = 1'b0;
    do_reset();
    checks += 5;
    if (locked !== 1'b0)      begin errors++; $display("FAIL reset_locked got=%0d want=0", locked); end
    if (err_pulse !== 1'b0)   begin errors++; $display("FAIL reset_pulse got=%0d want=0", err_pulse); end
    if (err_kind !== 2'b00)   begin errors++; $display("FAIL reset_kind got=%b want=00", err_kind); end
    if (err_count !== 16'd0)  begin errors++; $display("FAIL reset_errcnt got=%0d want=0", err_count); end
    if (wrap_count !== 16'd0) begin errors++; $display("FAIL reset_wrap got=%0d want=0", wrap_count); end
  endtask

  task automatic test_continuous();
    int pulses = 0;
    for (int i = 0; i < 520; i++) begin
      cyc(1'b1);
      if (i == 0) begin
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL cont_lock_first got=%0d want=1", locked); end
      end
      if (err_pulse !== 1'b0) pulses++;
    end
    checks += 4;
    if (pulses != 0)          begin errors++; $display("FAIL cont_pulses got=%0d want=0", pulses); end
    if (err_count !== 16'd0)  begin errors++; $display("FAIL cont_errcnt got=%0d want=0", err_count); end
    if (wrap_count !== 16'd2) begin errors++; $display("FAIL cont_wrap got=%0d want=2", wrap_count); end
    if (locked !== 1'b1)      begin errors++; $display("FAIL cont_locked got=%0d want=1", locked); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      if (locked !== 1'b1 || err_pulse !== 1'b0 || wrap_count !== 16'(m_wrap)) bad++;
    end
    checks += 3;
    if (bad != 0)                   begin errors++; $display("FAIL rand_cycles bad=%0d want=0", bad); end
    if (err_count !== 16'd0)        begin errors++; $display("FAIL rand_errcnt got=%0d want=0", err_count); end
    if (wrap_count !== 16'(m_wrap)) begin errors++; $display("FAIL rand_wrap got=%0d want=%0d", wrap_count, m_wrap); end
  endtask

  task automatic test_force_count();
    do_reset();
    for (int i = 0; i < 64 && c_cnt != 8'h10; i++) cyc(1'b1);
    count = 8'h55;
    cyc(1'b1);
    checks += 4;
    if (err_pulse !== 1'b1)  begin errors++; $display("FAIL force_pulse got=%0d want=1", err_pulse); end
    if (err_kind !== 2'b01)  begin errors++; $display("FAIL force_kind got=%b want=01", err_kind); end
    if (err_count !== 16'd1) begin errors++; $display("FAIL force_errcnt got=%0d want=1", err_count); end
    if (locked !== 1'b0)     begin errors++; $display("FAIL force_locked got=%0d want=0", locked); end
    cyc(1'b1);
    checks += 2;
    if (err_pulse !== 1'b1)  begin errors++; $display("FAIL force2_pulse got=%0d want=1", err_pulse); end
    if (err_count !== 16'd2) begin errors++; $display("FAIL force2_errcnt got=%0d want=2", err_count); end
    for (int i = 0; i < 4; i++) begin
      cyc($urandom_range(0, 1) != 0);
      checks++;
      if (locked !== ((i == 3) ? 1'b1 : 1'b0))
        begin errors++; $display("FAIL relock_%0d got=%0d want=%0d", i, locked, (i == 3)); end
    end
    checks++;
    if (err_count !== 16'(m_err)) begin errors++; $display("FAIL relock_errcnt got=%0d want=%0d", err_count, m_err); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16 && c_cnt != 8'h04; i++) cyc(1'b1);
    overflow = 1'b1;
    cyc(1'b1);
    checks += 4;
    if (err_kind !== 2'b10)  begin errors++; $display("FAIL ovf_kind got=%b want=10", err_kind); end
    if (err_count !== 16'd1) begin errors++; $display("FAIL ovf_errcnt got=%0d want=1", err_count); end
    if (locked !== 1'b0)     begin errors++; $display("FAIL ovf_locked got=%0d want=0", locked); end
    if (err_pulse !== 1'b1)  begin errors++; $display("FAIL ovf_pulse got=%0d want=1", err_pulse); end
    cyc(1'b1);
    checks += 2;
    if (err_pulse !== 1'b0)  begin errors++; $display("FAIL ovf_after_pulse got=%0d want=0", err_pulse); end
    if (err_count !== 16'd1) begin errors++; $display("FAIL ovf_after_errcnt got=%0d want=1", err_count); end
  endtask

  task automatic test_clear();
    clear_err = 1'b1;
    cyc(1'b1);
    clear_err = 1'b0;
    checks += 3;
    if (err_count !== 16'd0)          begin errors++; $display("FAIL clr_errcnt got=%0d want=0", err_count); end
    if (err_kind !== 2'b00)           begin errors++; $display("FAIL clr_kind got=%b want=00", err_kind); end
    if (locked !== logic'(m_locked))  begin errors++; $display("FAIL clr_locked got=%0d want=%0d", locked, m_locked); end
    clear_err = 1'b1;
    count = c_cnt ^ 8'h3C;
    cyc(1'b1);
    clear_err = 1'b0;
    checks += 3;
    if (err_count !== 16'd1) begin errors++; $display("FAIL clrmis_errcnt got=%0d want=1", err_count); end
    if (err_count2 !== 2'd1) begin errors++; $display("FAIL clrmis_errcnt2 got=%0d want=1", err_count2); end
    if (err_kind !== 2'b01)  begin errors++; $display("FAIL clrmis_kind got=%b want=01", err_kind); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      count = (i % 2 != 0) ? 8'hA0 : 8'h50;
      cyc(1'b0);
      checks++;
      if (err_pulse !== 1'b1) begin errors++; $display("FAIL b2b_pulse_%0d got=%0d want=1", i, err_pulse); end
    end
    checks += 3;
    if (err_count2 !== 2'd3)      begin errors++; $display("FAIL b2b_sat got=%0d want=3", err_count2); end
    if (err_count !== 16'(m_err)) begin errors++; $display("FAIL b2b_errcnt got=%0d want=%0d", err_count, m_err); end
    if (locked !== 1'b0)          begin errors++; $display("FAIL b2b_locked got=%0d want=0", locked); end
  endtask

  task automatic test_reset_in_fault();
    rst = 1'b1;
    cyc(1'b0);
    checks += 6;
    if (locked !== 1'b0)      begin errors++; $display("FAIL rstf_locked got=%0d want=0", locked); end
    if (err_pulse !== 1'b0)   begin errors++; $display("FAIL rstf_pulse got=%0d want=0", err_pulse); end
    if (err_kind !== 2'b00)   begin errors++; $display("FAIL rstf_kind got=%b want=00", err_kind); end
    if (err_count !== 16'd0)  begin errors++; $display("FAIL rstf_errcnt got=%0d want=0", err_count); end
    if (err_count2 !== 2'd0)  begin errors++; $display("FAIL rstf_errcnt2 got=%0d want=0", err_count2); end
    if (wrap_count !== 16'd0) begin errors++; $display("FAIL rstf_wrap got=%0d want=0", wrap_count); end
    rst = 1'b0;
    cyc(1'b1);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL rstf_relock got=%0d want=1", locked); end
    cyc(1'b1);
    checks++;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL rstf_clean got=%0d want=0", err_pulse); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0;
    model_reset();
    test_reset();
    test_continuous();
    test_random();
    test_force_count();
    test_overflow();
    test_clear();
    test_back_to_back();
    test_reset_in_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
